// File: rtl/multi_cycle_control_if.sv
// Control/status bundle between the multi-cycle LEGv8 controller (master)
// and the shared-ALU / unified-memory datapath (slave).
interface multi_cycle_control_if #(
  parameter int OPC_W   = 11,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 32
);
  logic [OPC_W-1:0]   Opcode;
  logic               Zero;
  logic               MemReady;
  logic               PCWrite;
  logic               PCSrc;
  logic               IRWrite;
  logic               Reg2Loc;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic               MemRead;
  logic               MemWrite;
  logic               MemToReg;
  logic               RegWrite;
  logic [2:0]         State;
  logic               Illegal;
  logic               Retire;
  logic [CNT_W-1:0]   InstrCount;

  modport master (
    input  Opcode, Zero, MemReady,
    output PCWrite, PCSrc, IRWrite, Reg2Loc, ALUSrcA, ALUSrcB, ALUOp,
           MemRead, MemWrite, MemToReg, RegWrite, State, Illegal, Retire,
           InstrCount
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  PCWrite, PCSrc, IRWrite, Reg2Loc, ALUSrcA, ALUSrcB, ALUOp,
           MemRead, MemWrite, MemToReg, RegWrite, State, Illegal, Retire,
           InstrCount
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB with memory stall, timeout and trap.
// Define MULTI_CYCLE_PERF_CNT_EN to enable the retired-instruction counter (InstrCount).
module multi_cycle_control #(
  parameter int OPC_W   = 11,
  parameter int ALUOP_W = 2,
  parameter int MEM_TMO = 16,
  parameter int CNT_W   = 32
) (
  input  logic                    CLK,
  input  logic                    Reset,
  multi_cycle_control_if.master   bus
);

  localparam int TMO_W = (MEM_TMO > 1) ? $clog2(MEM_TMO + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_ILL, C_R, C_ORRI, C_LDUR, C_STUR, C_CBZ, C_B
  } opc_class_e;

  function automatic opc_class_e classify(input logic [10:0] op);
    opc_class_e c;
    casez (op)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000,
      11'b11010011011: c = C_R;
      11'b1011001000?: c = C_ORRI;
      11'b11111000010: c = C_LDUR;
      11'b11111000000: c = C_STUR;
      11'b10110100???: c = C_CBZ;
      11'b000101?????: c = C_B;
      default:         c = C_ILL;
    endcase
    return c;
  endfunction

  state_e            state_q, state_d;
  logic [10:0]       opc_q, opc_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic [10:0]       opc_in;
  opc_class_e        dec_class;
  opc_class_e        cur_class;
  logic              stalled;
  logic              tmo_hit;

  logic              pc_write, pc_src, ir_write, reg2loc, alu_src_a;
  logic [1:0]        alu_src_b, alu_op;
  logic              mem_read, mem_write, mem_to_reg, reg_write, retire;

  assign opc_in    = bus.Opcode[OPC_W-1 -: 11];
  assign dec_class = classify(opc_in);
  assign cur_class = classify(opc_q);

  // Outputs depend on State/OpcReg, plus MemReady/Zero where the handshake
  // or branch outcome must act in the same cycle it is observed.
  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    reg2loc    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;

    stalled = ((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.MemReady;
    tmo_hit = 1'b0;
    if (MEM_TMO > 0) begin
      tmo_hit = stalled && (tmo_q == TMO_W'(MEM_TMO - 1));
    end

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (bus.MemReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        opc_d     = opc_in;
        alu_src_b = 2'b10;
        if (dec_class == C_B) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (dec_class == C_ILL) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        case (cur_class)
          C_R: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          C_ORRI: begin
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
            state_d   = S_WB;
          end
          C_LDUR, C_STUR: begin
            alu_src_b = 2'b10;
            state_d   = S_MEM;
          end
          C_CBZ: begin
            reg2loc  = 1'b1;
            alu_op   = 2'b01;
            pc_src   = 1'b1;
            pc_write = bus.Zero;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (cur_class == C_STUR) begin
          mem_write = 1'b1;
          reg2loc   = 1'b1;
          if (bus.MemReady) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (cur_class == C_LDUR) begin
          mem_read = 1'b1;
          if (bus.MemReady) begin
            state_d = S_WB;
          end
        end else begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cur_class == C_LDUR);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase

    if (tmo_hit) begin
      state_d = S_TRAP;
    end

    tmo_d = tmo_q;
    if (MEM_TMO == 0 || state_d != state_q) begin
      tmo_d = '0;
    end else if (stalled) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef MULTI_CYCLE_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Retire never fires in TRAP, so the count naturally holds there.
  always_comb begin
    cnt_d = cnt_q;
    if (retire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.InstrCount = cnt_q;
`else
  assign bus.InstrCount = '0;
`endif

  always_comb begin
    bus.ALUOp      = '0;
    bus.ALUOp[1:0] = alu_op;
  end

  assign bus.PCWrite  = pc_write;
  assign bus.PCSrc    = pc_src;
  assign bus.IRWrite  = ir_write;
  assign bus.Reg2Loc  = reg2loc;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.MemToReg = mem_to_reg;
  assign bus.RegWrite = reg_write;
  assign bus.State    = state_q;
  assign bus.Illegal  = (state_q == S_TRAP);
  assign bus.Retire   = retire;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: directed per-cycle vectors pushed by
// the stimulus process, popped and compared by a negedge monitor.
module tb_multi_cycle_control;

  localparam int MEM_TMO = 16;

  // {PCWrite,PCSrc,IRWrite,Reg2Loc,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],
  //  MemRead,MemWrite,MemToReg,RegWrite,Illegal,Retire}
  localparam logic [14:0] V_FETCH_R  = 15'b101000100100000;
  localparam logic [14:0] V_FETCH_S  = 15'b000000100100000;
  localparam logic [14:0] V_DEC      = 15'b000001000000000;
  localparam logic [14:0] V_DEC_B    = 15'b110001000000001;
  localparam logic [14:0] V_EX_R     = 15'b000010010000000;
  localparam logic [14:0] V_EX_ORRI  = 15'b000011010000000;
  localparam logic [14:0] V_EX_MEM   = 15'b000011000000000;
  localparam logic [14:0] V_EX_CBZ1  = 15'b110110001000001;
  localparam logic [14:0] V_EX_CBZ0  = 15'b010110001000001;
  localparam logic [14:0] V_MEM_LD   = 15'b000000000100000;
  localparam logic [14:0] V_MEM_ST0  = 15'b000100000010000;
  localparam logic [14:0] V_MEM_ST1  = 15'b000100000010001;
  localparam logic [14:0] V_WB_LD    = 15'b000000000001101;
  localparam logic [14:0] V_WB       = 15'b000000000000101;
  localparam logic [14:0] V_TRAP     = 15'b000000000000010;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_ORRI = 11'b10110010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010111111;
  localparam logic [10:0] OP_ILL  = 11'b11111111111;

  typedef struct packed {
    logic [2:0]  st;
    logic [14:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  logic CLK;
  logic Reset;
  exp_t exp_q[$];
  logic [31:0] exp_cnt;
  int   checks;
  int   failures;

  multi_cycle_control_if #(.OPC_W(11), .ALUOP_W(2), .CNT_W(32)) bus ();

  multi_cycle_control #(
    .OPC_W   (11),
    .ALUOP_W (2),
    .MEM_TMO (MEM_TMO),
    .CNT_W   (32)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    exp_t        e;
    logic [14:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {bus.PCWrite, bus.PCSrc, bus.IRWrite, bus.Reg2Loc, bus.ALUSrcA,
             bus.ALUSrcB, bus.ALUOp[1:0], bus.MemRead, bus.MemWrite,
             bus.MemToReg, bus.RegWrite, bus.Illegal, bus.Retire};
      checks++;
      if (bus.State !== e.st) begin
        failures++;
        $display("FAIL state t=%0t actual=%0d required=%0d", $time, bus.State, e.st);
      end
      checks++;
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL ctl t=%0t actual=%b required=%b", $time, act, e.ctl);
      end
      checks++;
      if (bus.InstrCount !== e.cnt) begin
        failures++;
        $display("FAIL instr_count t=%0t actual=%0d required=%0d", $time, bus.InstrCount, e.cnt);
      end
    end
  end

  task automatic step(input logic rst, input logic [10:0] op, input logic mr,
                      input logic z, input logic push, input logic [2:0] st,
                      input logic [14:0] ctl);
    Reset        = rst;
    bus.Opcode   = op;
    bus.MemReady = mr;
    bus.Zero     = z;
    if (push) begin
      exp_q.push_back('{st: st, ctl: ctl, cnt: exp_cnt});
    end
    if (rst) begin
      exp_cnt = '0;
    end else if (push && ctl[0]) begin
`ifdef MULTI_CYCLE_PERF_CNT_EN
      exp_cnt = exp_cnt + 1;
`endif
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = '0;
    bus.Opcode   = '0;
    bus.MemReady = 1'b1;
    bus.Zero     = 1'b0;
    Reset        = 1'b1;
    @(posedge CLK);
    #1;

    // Reset: second cycle already reflects FETCH.
    step(1, OP_ADD, 1, 0, 0, 3'd0, V_FETCH_R);
    step(1, OP_ADD, 1, 0, 1, 3'd0, V_FETCH_R);

    // ADD
    step(0, OP_ADD, 1, 0, 1, 3'd0, V_FETCH_R);
    step(0, OP_ADD, 1, 0, 1, 3'd1, V_DEC);
    step(0, OP_ADD, 1, 0, 1, 3'd2, V_EX_R);
    step(0, OP_ADD, 1, 0, 1, 3'd4, V_WB);

    // LDUR with 3 wait cycles in MEM
    step(0, OP_LDUR, 1, 0, 1, 3'd0, V_FETCH_R);
    step(0, OP_LDUR, 1, 0, 1, 3'd1, V_DEC);
    step(0, OP_LDUR, 1, 0, 1, 3'd2, V_EX_MEM);
    for (int i = 0; i < 3; i++) step(0, OP_LDUR, 0, 0, 1, 3'd3, V_MEM_LD);
    step(0, OP_LDUR, 1, 0, 1, 3'd3, V_MEM_LD);
    step(0, OP_LDUR, 1, 0, 1, 3'd4, V_WB_LD);

    // CBZ taken, then not taken
    step(0, OP_CBZ, 1, 1, 1, 3'd0, V_FETCH_R);
    step(0, OP_CBZ, 1, 1, 1, 3'd1, V_DEC);
    step(0, OP_CBZ, 1, 1, 1, 3'd2, V_EX_CBZ1);
    step(0, OP_CBZ, 1, 0, 1, 3'd0, V_FETCH_R);
    step(0, OP_CBZ, 1, 0, 1, 3'd1, V_DEC);
    step(0, OP_CBZ, 1, 0, 1, 3'd2, V_EX_CBZ0);

    // B with two-cycle fetch stall
    step(0, OP_B, 0, 0, 1, 3'd0, V_FETCH_S);
    step(0, OP_B, 0, 0, 1, 3'd0, V_FETCH_S);
    step(0, OP_B, 1, 0, 1, 3'd0, V_FETCH_R);
    step(0, OP_B, 1, 0, 1, 3'd1, V_DEC_B);

    // ORRI, SUB, STUR zero-wait
    step(0, OP_ORRI, 1, 0, 1, 3'd0, V_FETCH_R);
    step(0, OP_ORRI, 1, 0, 1, 3'd1, V_DEC);
    step(0, OP_ORRI, 1, 0, 1, 3'd2, V_EX_ORRI);
    step(0, OP_ORRI, 1, 0, 1, 3'd4, V_WB);
    step(0, OP_SUB, 1, 0, 1, 3'd0, V_FETCH_R);
    step(0, OP_SUB, 1, 0, 1, 3'd1, V_DEC);
    step(0, OP_SUB, 1, 0, 1, 3'd2, V_EX_R);
    step(0, OP_SUB, 1, 0, 1, 3'd4, V_WB);
    step(0, OP_STUR, 1, 0, 1, 3'd0, V_FETCH_R);
    step(0, OP_STUR, 1, 0, 1, 3'd1, V_DEC);
    step(0, OP_STUR, 1, 0, 1, 3'd2, V_EX_MEM);
    step(0, OP_STUR, 1, 0, 1, 3'd3, V_MEM_ST1);

    // Illegal opcode traps, sticky until reset
    step(0, OP_ILL, 1, 0, 1, 3'd0, V_FETCH_R);
    step(0, OP_ILL, 1, 0, 1, 3'd1, V_DEC);
    step(0, OP_ILL, 1, 0, 1, 3'd5, V_TRAP);
    step(0, OP_ADD, 0, 1, 1, 3'd5, V_TRAP);
    step(0, OP_ADD, 1, 0, 1, 3'd5, V_TRAP);
    step(1, OP_ADD, 1, 0, 0, 3'd5, V_TRAP);
    step(0, OP_ADD, 1, 0, 1, 3'd0, V_FETCH_R);

    // STUR memory timeout: 16 MEM cycles, then TRAP
    step(0, OP_STUR, 1, 0, 1, 3'd1, V_DEC);
    step(0, OP_STUR, 1, 0, 1, 3'd2, V_EX_MEM);
    for (int i = 0; i < MEM_TMO; i++) step(0, OP_STUR, 0, 0, 1, 3'd3, V_MEM_ST0);
    step(0, OP_STUR, 0, 0, 1, 3'd5, V_TRAP);
    step(0, OP_STUR, 1, 0, 1, 3'd5, V_TRAP);
    step(1, OP_STUR, 1, 0, 0, 3'd5, V_TRAP);

    // Reset mid-stall abandons the access
    step(0, OP_STUR, 1, 0, 1, 3'd0, V_FETCH_R);
    step(0, OP_STUR, 1, 0, 1, 3'd1, V_DEC);
    step(0, OP_STUR, 1, 0, 1, 3'd2, V_EX_MEM);
    for (int i = 0; i < 5; i++) step(0, OP_STUR, 0, 0, 1, 3'd3, V_MEM_ST0);
    step(1, OP_STUR, 0, 0, 0, 3'd3, V_MEM_ST0);
    step(0, OP_ADD, 1, 0, 1, 3'd0, V_FETCH_R);
    step(0, OP_ADD, 1, 0, 1, 3'd1, V_DEC);

    repeat (2) @(posedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
